// File: rtl/gray_sobel_ctrl_pkg.sv
// ============================================================================
// Module  : gray_sobel_ctrl_pkg
// Brief   : Frame sequencer state encoding and processing-mode constants.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package gray_sobel_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FLUSH = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [1:0] MODE_BYPASS     = 2'b00;
    localparam logic [1:0] MODE_GRAY       = 2'b01;
    localparam logic [1:0] MODE_SOBEL      = 2'b10;
    localparam logic [1:0] MODE_GRAY_SOBEL = 2'b11;

endpackage

`default_nettype wire

// File: rtl/gray_sobel_flush_gen.sv
// ============================================================================
// Module  : gray_sobel_flush_gen
// Brief   : Paces FLUSH_PX zero-pixel strobes, one every FLUSH_GAP cycles.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_sobel_flush_gen #(
    parameter int FLUSH_PX  = 9,
    parameter int FLUSH_GAP = 1
) (
    input  logic clk_i,
    input  logic nreset_i,
    input  logic start_i,
    output logic px_vld_o,
    output logic done_o
);

    localparam int FCW = $clog2(FLUSH_PX + 1);
    localparam int GCW = $clog2(FLUSH_GAP + 1);

    localparam logic [FCW-1:0] c_last_px    = FCW'(FLUSH_PX - 1);
    localparam logic [GCW-1:0] c_gap_reload = GCW'(FLUSH_GAP - 1);

    logic           r_active;
    logic [FCW-1:0] r_cnt;
    logic [GCW-1:0] r_gap;
    logic           w_emit;

    // Gap timer loads zero on start so the first pixel goes out immediately.
    assign w_emit   = r_active && (r_gap == '0);
    assign px_vld_o = w_emit;
    assign done_o   = w_emit && (r_cnt == c_last_px);

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_gap    <= '0;
        end else if (start_i) begin
            r_active <= 1'b1;
            r_cnt    <= '0;
            r_gap    <= '0;
        end else if (r_active) begin
            if (w_emit) begin
                r_gap <= c_gap_reload;
                if (r_cnt == c_last_px) begin
                    r_active <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + FCW'(1);
                end
            end else begin
                r_gap <= r_gap - GCW'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/parameters.svh
// ============================================================================
// File    : parameters.svh
// Brief   : Global pixel width shared by the grayscale/Sobel pipeline.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none
`ifndef GRAY_SOBEL_PARAMETERS_SVH
`define GRAY_SOBEL_PARAMETERS_SVH
`define MAX_PIXEL_BITS 8
`endif
`default_nettype wire

// File: rtl/gray_sobel_frame_ctrl.sv
// ============================================================================
// Module  : gray_sobel_frame_ctrl
// Brief   : Frame sequencer between SPI pixel I/O and the gray/Sobel datapath.
// Rev     : 1.0 - initial release
// ============================================================================
`include "parameters.svh"
`default_nettype none

module gray_sobel_frame_ctrl
    import gray_sobel_ctrl_pkg::*;
#(
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8,
    parameter int FLUSH_PX   = IMG_WIDTH + 1,
    parameter int FLUSH_GAP  = 1,
    parameter int TIMEOUT    = 1024
) (
    input  logic                       clk_i,
    input  logic                       nreset_i,
    input  logic [1:0]                 select_i,
    input  logic                       start_i,
    input  logic                       in_px_rdy_i,
    input  logic [`MAX_PIXEL_BITS-1:0] in_pixel_i,
    output logic [1:0]                 dp_select_o,
    output logic                       dp_start_sobel_o,
    output logic                       dp_px_rdy_o,
    output logic [`MAX_PIXEL_BITS-1:0] dp_pixel_o,
    input  logic                       dp_px_rdy_i,
    input  logic [`MAX_PIXEL_BITS-1:0] dp_pixel_i,
    output logic                       out_px_rdy_o,
    output logic [`MAX_PIXEL_BITS-1:0] out_pixel_o,
    output logic                       busy_o,
    output logic                       frame_done_o,
    output logic                       overrun_o,
    output logic                       timeout_o
);

    localparam int PB  = `MAX_PIXEL_BITS;
    localparam int N   = IMG_WIDTH * IMG_HEIGHT;
    localparam int CW  = $clog2(N + 1);
    localparam int WCW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0]  c_n       = CW'(N);
    localparam logic [CW-1:0]  c_n_last  = CW'(N - 1);
    localparam logic [WCW-1:0] c_wd_last = WCW'(TIMEOUT - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_mode;
    logic [CW-1:0]   r_in_cnt;
    logic [CW-1:0]   r_out_cnt;
    logic [WCW-1:0]  r_wdog;
    logic            r_overrun;
    logic            r_timeout;
    logic            r_dp_px_rdy;
    logic [PB-1:0]   r_dp_pixel;
    logic            r_out_px_rdy;
    logic [PB-1:0]   r_out_pixel;

    logic            w_active;
    logic            w_in_accept;
    logic            w_out_accept;
    logic            w_flush_start;
    logic            w_flush_px;
    logic            w_flush_done;
    logic            w_wd_expire;

    assign w_active     = (r_state == LOAD) || (r_state == FLUSH) || (r_state == DRAIN);
    assign w_in_accept  = (r_state == LOAD) && in_px_rdy_i;
    assign w_out_accept = w_active && dp_px_rdy_i && (r_out_cnt != c_n);

    gray_sobel_flush_gen #(
        .FLUSH_PX  (FLUSH_PX),
        .FLUSH_GAP (FLUSH_GAP)
    ) u_flush_gen (
        .clk_i    (clk_i),
        .nreset_i (nreset_i),
        .start_i  (w_flush_start),
        .px_vld_o (w_flush_px),
        .done_o   (w_flush_done)
    );

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_flush_start = 1'b0;
        w_wd_expire   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (w_in_accept && (r_in_cnt == c_n_last)) begin
                    if (r_mode[1]) begin
                        w_state_nxt   = FLUSH;
                        w_flush_start = 1'b1;
                    end else begin
                        w_state_nxt = DRAIN;
                    end
                end
            end
            FLUSH: begin
                if (w_flush_done) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Completion is checked first so it wins over a coincident expiry.
                if (r_out_cnt == c_n) begin
                    w_state_nxt = DONE;
                end else if (!dp_px_rdy_i && (r_wdog == c_wd_last)) begin
                    w_state_nxt = DONE;
                    w_wd_expire = 1'b1;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            r_mode       <= MODE_BYPASS;
            r_in_cnt     <= '0;
            r_out_cnt    <= '0;
            r_wdog       <= '0;
            r_overrun    <= 1'b0;
            r_timeout    <= 1'b0;
            r_dp_px_rdy  <= 1'b0;
            r_dp_pixel   <= '0;
            r_out_px_rdy <= 1'b0;
            r_out_pixel  <= '0;
        end else begin
            if ((r_state == IDLE) && start_i) begin
                r_mode    <= select_i;
                r_in_cnt  <= '0;
                r_out_cnt <= '0;
                r_overrun <= 1'b0;
                r_timeout <= 1'b0;
            end else begin
                if (w_in_accept) begin
                    r_in_cnt <= r_in_cnt + CW'(1);
                end
                if (w_out_accept) begin
                    r_out_cnt <= r_out_cnt + CW'(1);
                end
                if (in_px_rdy_i && (r_state != LOAD)) begin
                    r_overrun <= 1'b1;
                end
                if (w_wd_expire) begin
                    r_timeout <= 1'b1;
                end
            end

            if ((r_state == DRAIN) && !dp_px_rdy_i) begin
                r_wdog <= r_wdog + WCW'(1);
            end else begin
                r_wdog <= '0;
            end

            r_dp_px_rdy  <= w_in_accept || w_flush_px;
            r_dp_pixel   <= w_in_accept ? in_pixel_i : '0;
            r_out_px_rdy <= w_out_accept;
            r_out_pixel  <= w_out_accept ? dp_pixel_i : '0;
        end
    end

    assign dp_select_o      = r_mode;
    assign dp_start_sobel_o = w_active && r_mode[1];
    assign dp_px_rdy_o      = r_dp_px_rdy;
    assign dp_pixel_o       = r_dp_pixel;
    assign out_px_rdy_o     = r_out_px_rdy;
    assign out_pixel_o      = r_out_pixel;
    assign busy_o           = (r_state != IDLE);
    assign frame_done_o     = (r_state == DONE);
    assign overrun_o        = r_overrun;
    assign timeout_o        = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_gray_sobel_frame_ctrl.sv
// ============================================================================
// Module  : tb_gray_sobel_frame_ctrl
// Brief   : Directed self-checking bench for the frame sequencer (4x4 frame).
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gray_sobel_frame_ctrl;

    localparam int PB = 8;

    logic          clk = 1'b0;
    logic          nreset;
    logic [1:0]    select;
    logic          start;
    logic          in_rdy;
    logic [PB-1:0] in_pix;
    logic          dp_rdy;
    logic [PB-1:0] dp_pix;

    logic [1:0]    dp_select_o;
    logic          dp_start_sobel_o;
    logic          dp_px_rdy_o;
    logic [PB-1:0] dp_pixel_o;
    logic          out_px_rdy_o;
    logic [PB-1:0] out_pixel_o;
    logic          busy_o;
    logic          frame_done_o;
    logic          overrun_o;
    logic          timeout_o;

    int checks = 0;
    int errors = 0;

    gray_sobel_frame_ctrl #(
        .IMG_WIDTH  (4),
        .IMG_HEIGHT (4),
        .FLUSH_PX   (5),
        .FLUSH_GAP  (2),
        .TIMEOUT    (32)
    ) dut (
        .clk_i            (clk),
        .nreset_i         (nreset),
        .select_i         (select),
        .start_i          (start),
        .in_px_rdy_i      (in_rdy),
        .in_pixel_i       (in_pix),
        .dp_select_o      (dp_select_o),
        .dp_start_sobel_o (dp_start_sobel_o),
        .dp_px_rdy_o      (dp_px_rdy_o),
        .dp_pixel_o       (dp_pixel_o),
        .dp_px_rdy_i      (dp_rdy),
        .dp_pixel_i       (dp_pix),
        .out_px_rdy_o     (out_px_rdy_o),
        .out_pixel_o      (out_pixel_o),
        .busy_o           (busy_o),
        .frame_done_o     (frame_done_o),
        .overrun_o        (overrun_o),
        .timeout_o        (timeout_o)
    );

    always #5 clk = ~clk;

    // Passive recorder of everything the DUT emits, sampled on the falling edge.
    logic [PB-1:0] dp_val  [0:255];
    int            dp_cyc  [0:255];
    logic [PB-1:0] out_val [0:255];
    int            out_cyc [0:255];
    int cyc = 0, dp_n = 0, out_n = 0, done_n = 0, done_cyc = 0, to_cyc = 0;
    int sob_hi = 0, sob_busy_lo = 0, sob_idle_hi = 0, idle_pix_nz = 0;
    logic to_prev = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (dp_px_rdy_o && dp_n < 256) begin
            dp_val[dp_n] <= dp_pixel_o;
            dp_cyc[dp_n] <= cyc;
            dp_n         <= dp_n + 1;
        end
        if (out_px_rdy_o && out_n < 256) begin
            out_val[out_n] <= out_pixel_o;
            out_cyc[out_n] <= cyc;
            out_n          <= out_n + 1;
        end
        if (frame_done_o) begin
            done_n   <= done_n + 1;
            done_cyc <= cyc;
        end
        if (timeout_o && !to_prev) to_cyc <= cyc;
        to_prev <= timeout_o;
        if (dp_start_sobel_o) sob_hi <= sob_hi + 1;
        if (busy_o && !frame_done_o && !dp_start_sobel_o) sob_busy_lo <= sob_busy_lo + 1;
        if (dp_start_sobel_o && (!busy_o || frame_done_o)) sob_idle_hi <= sob_idle_hi + 1;
        if (!dp_px_rdy_o && dp_pixel_o != '0) idle_pix_nz <= idle_pix_nz + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start  = 1'b0;
        in_rdy = 1'b0;
        in_pix = '0;
        dp_rdy = 1'b0;
        dp_pix = '0;
    endtask

    task automatic wait_done(input int base, input string tag);
        int k = 0;
        while (done_n == base && k < 80) begin
            step();
            k++;
        end
        checks++;
        if (done_n == base) begin
            errors++;
            $display("FAIL %s_done_wait: no frame_done_o within 80 cycles", tag);
        end
        step();
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        select = 2'b11;
        nreset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy_o, dp_select_o, dp_start_sobel_o, dp_px_rdy_o, dp_pixel_o, out_px_rdy_o,
             out_pixel_o, frame_done_o, overrun_o, timeout_o} !== 25'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b sel=%b dp_rdy=%b out_rdy=%b ov=%b to=%b, required all 0",
                     busy_o, dp_select_o, dp_px_rdy_o, out_px_rdy_o, overrun_o, timeout_o);
        end
        nreset = 1'b1;
        step();
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_without_start: busy_o=%b required 0", busy_o);
        end
    endtask

    task automatic test_gray();
        int b_dp = dp_n, b_out = out_n, b_done = done_n, b_shi = sob_hi, b_nz = idle_pix_nz;
        int bad = 0;
        select = 2'b01;
        start  = 1'b1;
        step();
        start  = 1'b0;
        select = 2'b00;
        checks++;
        if (busy_o !== 1'b1 || dp_select_o !== 2'b01) begin
            errors++;
            $display("FAIL gray_start: busy=%b sel=%b, required busy=1 sel=01", busy_o, dp_select_o);
        end
        // Datapath echoes each forwarded pixel three cycles after it appears.
        for (int i = 0; i < 20; i++) begin
            in_rdy = (i < 16);
            in_pix = (i < 16) ? PB'(i) : '0;
            dp_rdy = (i >= 4);
            dp_pix = (i >= 4) ? PB'(i - 4) : '0;
            step();
        end
        idle_inputs();
        wait_done(b_done, "gray");
        checks++;
        if (dp_n - b_dp !== 16) begin
            errors++;
            $display("FAIL gray_dp_count: got %0d required 16", dp_n - b_dp);
        end
        for (int i = 0; i < 16; i++) if (dp_val[b_dp + i] !== PB'(i)) bad++;
        for (int i = 0; i < 16; i++) if (out_val[b_out + i] !== PB'(i)) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL gray_pixel_values: %0d wrong, required 0", bad);
        end
        checks++;
        if (out_n - b_out !== 16 || done_n - b_done !== 1) begin
            errors++;
            $display("FAIL gray_out_done: outs=%0d dones=%0d, required 16 and 1", out_n - b_out, done_n - b_done);
        end
        checks++;
        if (sob_hi - b_shi !== 0 || idle_pix_nz - b_nz !== 0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL gray_sobel_idle: sobel_cycles=%0d idle_nz=%0d busy=%b, required 0 0 0",
                     sob_hi - b_shi, idle_pix_nz - b_nz, busy_o);
        end
    endtask

    task automatic test_sobel();
        int b_dp = dp_n, b_out = out_n, b_done = done_n, b_shi = sob_hi;
        int b_lo = sob_busy_lo, b_ih = sob_idle_hi;
        int bad = 0, gap_bad = 0;
        select = 2'b10;
        start  = 1'b1;
        step();
        start  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_rdy = 1'b1;
            in_pix = PB'(i + 1);
            step();
        end
        idle_inputs();
        repeat (12) step();
        for (int i = 0; i < 16; i++) begin
            dp_rdy = 1'b1;
            dp_pix = PB'(8'hA0 + i);
            step();
        end
        idle_inputs();
        wait_done(b_done, "sobel");
        checks++;
        if (dp_n - b_dp !== 21) begin
            errors++;
            $display("FAIL sobel_dp_count: got %0d required 21", dp_n - b_dp);
        end
        for (int i = 0; i < 16; i++) if (dp_val[b_dp + i] !== PB'(i + 1)) bad++;
        for (int j = 0; j < 5; j++) if (dp_val[b_dp + 16 + j] !== '0) bad++;
        for (int i = 0; i < 16; i++) if (out_val[b_out + i] !== PB'(8'hA0 + i)) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL sobel_pixel_values: %0d wrong, required 0", bad);
        end
        for (int j = 1; j < 5; j++) if (dp_cyc[b_dp + 16 + j] - dp_cyc[b_dp + 15 + j] != 2) gap_bad++;
        checks++;
        if (gap_bad !== 0) begin
            errors++;
            $display("FAIL sobel_flush_spacing: %0d gaps not 2 cycles, required 0", gap_bad);
        end
        checks++;
        if (sob_busy_lo - b_lo !== 0 || sob_idle_hi - b_ih !== 0 || sob_hi == b_shi) begin
            errors++;
            $display("FAIL sobel_enable: low_in_frame=%0d high_outside=%0d high=%0d, required 0 0 >0",
                     sob_busy_lo - b_lo, sob_idle_hi - b_ih, sob_hi - b_shi);
        end
        checks++;
        if (out_n - b_out !== 16 || done_n - b_done !== 1 || dp_select_o !== 2'b10) begin
            errors++;
            $display("FAIL sobel_end: outs=%0d dones=%0d sel=%b, required 16 1 10",
                     out_n - b_out, done_n - b_done, dp_select_o);
        end
    endtask

    task automatic test_timeout();
        int b_out = out_n, b_done = done_n;
        int k = 0;
        select = 2'b01;
        start  = 1'b1;
        step();
        start  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_rdy = 1'b1;
            in_pix = PB'(i);
            step();
        end
        idle_inputs();
        repeat (2) step();
        for (int i = 0; i < 10; i++) begin
            dp_rdy = 1'b1;
            dp_pix = PB'(8'h60 + i);
            step();
        end
        idle_inputs();
        while (!timeout_o && k < 80) begin
            step();
            k++;
        end
        checks++;
        if (timeout_o !== 1'b1) begin
            errors++;
            $display("FAIL timeout_flag: timeout_o=%b after 80 cycles, required 1", timeout_o);
        end
        step();
        checks++;
        if (to_cyc - out_cyc[b_out + 9] !== 32 || done_cyc !== to_cyc) begin
            errors++;
            $display("FAIL timeout_latency: %0d cycles after 10th output (done at +%0d), required 32 and 32",
                     to_cyc - out_cyc[b_out + 9], done_cyc - out_cyc[b_out + 9]);
        end
        step();
        checks++;
        if (out_n - b_out !== 10 || done_n - b_done !== 1 || busy_o !== 1'b0 || timeout_o !== 1'b1) begin
            errors++;
            $display("FAIL timeout_end: outs=%0d dones=%0d busy=%b to=%b, required 10 1 0 1",
                     out_n - b_out, done_n - b_done, busy_o, timeout_o);
        end
    endtask

    task automatic test_overrun();
        int b_dp = dp_n, b_out = out_n, b_done = done_n, b_shi = sob_hi;
        int bad = 0;
        select = 2'b01;
        start  = 1'b1;
        step();
        start  = 1'b0;
        checks++;
        if (timeout_o !== 1'b0 || overrun_o !== 1'b0) begin
            errors++;
            $display("FAIL start_clears_flags: to=%b ov=%b, required 0 0", timeout_o, overrun_o);
        end
        for (int i = 0; i < 17; i++) begin
            in_rdy = 1'b1;
            in_pix = PB'(i + 8'h40);
            start  = (i == 5);
            select = (i == 5) ? 2'b10 : 2'b01;
            step();
        end
        idle_inputs();
        select = 2'b00;
        step();
        checks++;
        if (overrun_o !== 1'b1 || dp_n - b_dp !== 16 || dp_select_o !== 2'b01 || sob_hi !== b_shi) begin
            errors++;
            $display("FAIL overrun_load: ov=%b dp_strobes=%0d sel=%b sobel_cycles=%0d, required 1 16 01 0",
                     overrun_o, dp_n - b_dp, dp_select_o, sob_hi - b_shi);
        end
        for (int i = 0; i < 18; i++) begin
            dp_rdy = 1'b1;
            dp_pix = PB'(8'h30 + i);
            step();
        end
        idle_inputs();
        wait_done(b_done, "overrun");
        for (int i = 0; i < 16; i++) if (out_val[b_out + i] !== PB'(8'h30 + i)) bad++;
        checks++;
        if (out_n - b_out !== 16 || bad !== 0) begin
            errors++;
            $display("FAIL extra_outputs: forwarded=%0d wrong=%0d, required 16 0", out_n - b_out, bad);
        end
        checks++;
        if (done_n - b_done !== 1 || overrun_o !== 1'b1 || dp_select_o !== 2'b01) begin
            errors++;
            $display("FAIL overrun_end: dones=%0d ov=%b sel=%b, required 1 1 01",
                     done_n - b_done, overrun_o, dp_select_o);
        end
    endtask

    task automatic test_reset_mid();
        select = 2'b10;
        start  = 1'b1;
        step();
        start  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_rdy = 1'b1;
            in_pix = PB'(i + 1);
            step();
        end
        idle_inputs();
        step();
        in_rdy = 1'b1;
        dp_rdy = 1'b1;
        dp_pix = 8'h55;
        step();
        idle_inputs();
        checks++;
        if (overrun_o !== 1'b1 || out_pixel_o !== 8'h55 || busy_o !== 1'b1 || dp_start_sobel_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_precondition: ov=%b out=%h busy=%b sobel=%b, required 1 55 1 1",
                     overrun_o, out_pixel_o, busy_o, dp_start_sobel_o);
        end
        #2;
        nreset = 1'b0;
        #1;
        checks++;
        if ({busy_o, dp_select_o, dp_start_sobel_o, dp_px_rdy_o, dp_pixel_o, out_px_rdy_o,
             out_pixel_o, frame_done_o, overrun_o, timeout_o} !== 25'd0) begin
            errors++;
            $display("FAIL async_reset_outputs: busy=%b sel=%b sobel=%b out_rdy=%b out=%h ov=%b, required all 0",
                     busy_o, dp_select_o, dp_start_sobel_o, out_px_rdy_o, out_pixel_o, overrun_o);
        end
        @(posedge clk);
        #1;
        nreset = 1'b1;
        step();
        test_gray();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        test_reset();
        test_gray();
        test_sobel();
        test_timeout();
        test_overrun();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
